// File: rtl/lfsr_cfg_loader.sv
// Loads seed/stop words into the LFSR from a host byte stream, verifies them by readback, runs the LFSR.
// Write: last byte n -> config_rdy n+1 -> IDLE n+4; byte_ready_o drops outside IDLE/COLLECT.
module lfsr_cfg_loader #(
  parameter int PIXEL_BITS = 24,
  parameter int RUN_CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  sel_i,
  output logic                  byte_ready_o,
  input  logic                  start_i,
  output logic                  config_o,
  output logic                  config_rdy_o,
  output logic [PIXEL_BITS-1:0] config_data_o,
  input  logic                  config_done_i,
  input  logic [PIXEL_BITS-1:0] config_readback_i,
  output logic                  lfsr_en_o,
  input  logic [PIXEL_BITS-1:0] lfsr_data_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  run_done_o,
  output logic                  run_timeout_o,
  output logic [RUN_CNT_W-1:0]  run_len_o
);

  localparam int NBYTES = (PIXEL_BITS + 7) / 8;
  localparam int BCNT_W = $clog2(NBYTES + 1);
  localparam logic [BCNT_W-1:0]    LAST_BYTE = BCNT_W'(NBYTES);
  localparam logic [RUN_CNT_W-1:0] RUN_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_WAIT_DONE, S_VERIFY, S_RUN, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PIXEL_BITS-1:0] shreg_q, stop_copy_q;
  logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_nxt;
  logic [1:0]            wait_cnt_q;
  logic [RUN_CNT_W-1:0]  run_cnt_q, run_len_q;
  logic                  sel_q, seed_ok_q, stop_ok_q, err_q, timeout_q;
  logic                  start_acc, byte_acc, last_byte, wait_exp, rb_match, stop_hit, run_sat;

  assign start_acc    = (state_q == S_IDLE) && start_i && seed_ok_q && stop_ok_q;
  assign byte_acc     = byte_valid_i && byte_ready_o;
  assign byte_cnt_nxt = (state_q == S_IDLE) ? BCNT_W'(1) : byte_cnt_q + BCNT_W'(1);
  assign last_byte    = (byte_cnt_nxt == LAST_BYTE);
  assign wait_exp     = (wait_cnt_q == 2'd3);
  assign rb_match     = (config_readback_i == shreg_q);
  assign stop_hit     = (lfsr_data_i == stop_copy_q);
  assign run_sat      = (run_cnt_q == RUN_MAX);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc)     state_d = S_RUN;
        else if (byte_acc) state_d = last_byte ? S_WRITE : S_COLLECT;
      end
      S_COLLECT:   if (byte_acc && last_byte) state_d = S_WRITE;
      S_WRITE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (config_done_i) state_d = S_VERIFY;
        else if (wait_exp) state_d = S_IDLE;
      end
      S_VERIFY:    state_d = S_IDLE;
      S_RUN:       if (stop_hit || run_sat) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    config_o     = 1'b0;
    config_rdy_o = 1'b0;
    lfsr_en_o    = 1'b0;
    run_done_o   = 1'b0;
    busy_o       = (state_q != S_IDLE);
    unique case (state_q)
      // A qualified start claims the IDLE cycle, so a coincident byte is refused.
      S_IDLE:      byte_ready_o = !reset_i && !(start_i && seed_ok_q && stop_ok_q);
      S_COLLECT:   byte_ready_o = !reset_i;
      S_WRITE:     begin config_o = sel_q; config_rdy_o = 1'b1; end
      S_WAIT_DONE: config_o = sel_q;
      S_VERIFY:    config_o = sel_q;
      S_RUN:       lfsr_en_o = 1'b1;
      S_DONE:      run_done_o = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shreg_q     <= '0;
      stop_copy_q <= '0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      run_cnt_q   <= '0;
      run_len_q   <= '0;
      sel_q       <= 1'b0;
      seed_ok_q   <= 1'b0;
      stop_ok_q   <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (byte_acc) begin
        shreg_q    <= {shreg_q[PIXEL_BITS-9:0], byte_data_i};
        byte_cnt_q <= byte_cnt_nxt;
        if (state_q == S_IDLE) sel_q <= sel_i;
      end
      if (start_acc) begin
        run_cnt_q <= '0;
        timeout_q <= 1'b0;
      end
      unique case (state_q)
        S_WRITE: begin
          wait_cnt_q <= '0;
          if (sel_q) stop_ok_q <= 1'b0;
          else       seed_ok_q <= 1'b0;
        end
        S_WAIT_DONE: begin
          if (!config_done_i) begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
            if (wait_exp) err_q <= 1'b1;
          end
        end
        S_VERIFY: begin
          if (rb_match) begin
            if (sel_q) begin
              stop_ok_q   <= 1'b1;
              stop_copy_q <= shreg_q;
            end else begin
              seed_ok_q <= 1'b1;
            end
          end else begin
            err_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop_hit) begin
            run_len_q <= run_cnt_q;
          end else if (run_sat) begin
            run_len_q <= RUN_MAX;
            timeout_q <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + RUN_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign config_data_o = shreg_q;
  assign err_o         = err_q;
  assign run_timeout_o = timeout_q;
  assign run_len_o     = run_len_q;

endmodule

// File: doc/lfsr_cfg_loader.md
# lfsr_cfg_loader

Upstream configuration and run controller for the LFSR test-pattern generator. It assembles seed and stop words from an 8-bit host byte stream and writes them through the LFSR's config handshake (`config_i`/`config_rdy_i`/`config_data_i`, acknowledged by `config_done_o`). It verifies each write by reading the word back, then enables the LFSR on request. The run ends when the generated pattern equals the stop word or a cycle limit is reached.

## Interface
- `PIXEL_BITS`, 24, LFSR word width; must be ≥ 13.
- `RUN_CNT_W`, 16, width of the run-length counter.
- `NBYTES`, derived as ceil(`PIXEL_BITS`/8); not overridable.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `byte_valid_i` in 1: host byte valid.
- `byte_data_i` in 8: host byte, MSB-first within the word.
- `sel_i` in 1: word target, 0 = seed, 1 = stop; sampled on the first byte of a word.
- `byte_ready_o` out 1: loader accepts a byte this cycle.
- `start_i` in 1: request an LFSR run.
- `config_o` out 1: drives LFSR `config_i`.
- `config_rdy_o` out 1: drives LFSR `config_rdy_i`.
- `config_data_o` out `PIXEL_BITS`: drives LFSR `config_data_i`.
- `config_done_i` in 1: from LFSR `config_done_o`.
- `config_readback_i` in `PIXEL_BITS`: from LFSR `config_data_o`.
- `lfsr_en_o` out 1: drives LFSR `lfsr_en_i`.
- `lfsr_data_i` in `PIXEL_BITS`: from LFSR `lfsr_out`.
- `busy_o` out 1: state ≠ IDLE.
- `err_o` out 1: sticky error.
- `run_done_o` out 1: one-cycle pulse at end of run.
- `run_timeout_o` out 1: last run hit the counter limit.
- `run_len_o` out `RUN_CNT_W`: length of the last run.

## Operation
- States: IDLE, COLLECT, WRITE, WAIT_DONE, VERIFY, RUN, DONE.
- **Reset** (synchronous, any state): enter IDLE. All outputs go to 0, and so do the shift register, `seed_ok`, `stop_ok`, stored stop copy and counters.
- **IDLE**
  - `byte_ready_o` = 1 unless a start is accepted this cycle. A qualified start has priority over a simultaneous byte, and that byte is not accepted.
  - A start is accepted only when `start_i` & `seed_ok` & `stop_ok`; the state then goes to RUN. Otherwise `start_i` is ignored and no error is raised.
  - Byte accept: latch `sel_i` and shift the byte in. Go to COLLECT, or to WRITE if `NBYTES` = 1.
- **COLLECT**
  - `byte_ready_o` = 1; `sel_i` is ignored.
  - Each accepted byte shifts: shreg ← {shreg[`PIXEL_BITS`-9:0], byte}.
  - When `NBYTES` bytes have been accepted, go to WRITE.
  - When `PIXEL_BITS` is not a multiple of 8, the upper bits of the first byte are discarded.
- **WRITE**: `config_rdy_o` = 1 for exactly one cycle, with `config_o` = latched sel and `config_data_o` = shreg. Go to WAIT_DONE.
- **WAIT_DONE**
  - `config_o` is held.
  - On `config_done_i`, go to VERIFY.
  - After 4 cycles without `config_done_i`: set `err_o`, clear the ok flag for the targeted word, go to IDLE.
- **VERIFY** (`config_o` held, one cycle): compare `config_readback_i` with shreg.
  - Match: set `seed_ok` or `stop_ok` as targeted. For a stop word, also copy shreg into the stop copy.
  - Mismatch: set `err_o` and clear that ok flag.
  - Then go to IDLE.
- **Overwrite**: rewriting either word clears its ok flag at WRITE until VERIFY succeeds.
- **RUN**
  - `lfsr_en_o` = 1; the counter starts at 0.
  - Each cycle, compare `lfsr_data_i` with the stop copy. On match: `run_len_o` ← counter, go to DONE.
  - Otherwise the counter increments. If the counter equals 2^`RUN_CNT_W`-1 without a match: `run_len_o` ← that value, `run_timeout_o` ← 1, go to DONE.
  - `byte_ready_o` = 0 and `start_i` is ignored.
- **DONE**: `run_done_o` = 1 for one cycle and `lfsr_en_o` = 0. Go to IDLE.
- `run_len_o` and `run_timeout_o` hold until the next RUN entry. On RUN entry, `run_timeout_o` clears.
- `err_o` clears only on reset.

## Timing
- `lfsr_en_o` = (state == RUN) and is registered-state decoded, so there is no glitch path from inputs.
- While the LFSR is disabled it reloads the seed each cycle. The first RUN cycle therefore sees `lfsr_data_i` = seed. A seed equal to the stop word gives `run_len_o` = 0.
- Byte-to-write latency: the last byte is accepted in cycle n and `config_rdy_o` is high in n+1.
- The LFSR acknowledges at n+2, VERIFY is at n+3 and IDLE at n+4.
- Minimum gap from a seed write to RUN is one IDLE cycle, which guarantees the LFSR has loaded the new seed.

## Test plan
- **Seed write**: reset, then bytes 0x12, 0x34, 0x56 with `sel_i` = 0. Required: one-cycle `config_rdy_o` with `config_o` = 0 and `config_data_o` = 0x123456. `seed_ok` is set after readback, and `err_o` stays 0.
- **Single-step run**: seed 0x000000, stop 0x000001, then pulse `start_i`. Required: `lfsr_en_o` high for 2 cycles, `run_done_o` pulse, `run_len_o` = 1, `run_timeout_o` = 0.
- **Seed equals stop**: seed = stop = 0xABCDEF, then start. Required: `run_len_o` = 0 and `run_done_o` on the second cycle after the start.
- **Config faults**
  - LFSR stub never asserts `config_done_i`: `err_o` = 1 exactly 4 cycles after WAIT_DONE entry, and start is then ignored.
  - Stub returns a readback with bit 0 flipped: `err_o` = 1 and the corresponding ok flag stays 0.
- **Counter saturation**: `RUN_CNT_W` = 4, stop word unreachable within 15 steps. Required: `run_len_o` = 15, `run_timeout_o` = 1, and the `run_done_o` pulse.
- **Simultaneous events and mid-run reset**
  - `start_i` and `byte_valid_i` together in IDLE with both flags ok: start wins and the byte is not accepted.
  - `reset_i` mid-RUN: next cycle `lfsr_en_o` = 0, IDLE, and all flags cleared.
